// File: rtl/prbs16_checker.sv
// Serial PRBS16 checker (x^16+x^14+x^13+x^11+1, Fibonacci form).
// Hunts for sync by loading received bits into its history, verifies a run of
// correct predictions, then free-runs its own LFSR and counts bit errors.
// Loss of lock is declared when too many errors land inside one window.
module prbs16_checker #(
  parameter int LOCK_COUNT  = 32,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_pulse,
  output logic             lock_lost
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int WP_W = $clog2(WIN_LEN);
  localparam int WE_W = $clog2(WIN_LEN + 1) + 1;
  localparam logic [WP_W-1:0]  WIN_LAST = WP_W'(WIN_LEN - 1);
  localparam logic [7:0]       LOCK_U   = 8'(LOCK_COUNT);
  localparam logic [31:0]      LOSS_U   = 32'(LOSS_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_reg, state_next;
  logic [15:0]      hist_reg, hist_next;
  logic [4:0]       fill_reg, fill_next;
  logic [7:0]       match_reg, match_next;
  logic [WP_W-1:0]  win_pos_reg, win_pos_next;
  logic [WE_W-1:0]  win_err_reg, win_err_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic             locked_reg, locked_next;
  logic             err_pulse_reg, err_pulse_next;
  logic             lock_lost_reg, lock_lost_next;

  logic             pred;
  logic             mism;
  logic [WE_W-1:0]  win_err_inc;

  // Prediction from the polynomial taps; mismatch against the received bit.
  assign pred        = hist_reg[15] ^ hist_reg[13] ^ hist_reg[12] ^ hist_reg[10];
  assign mism        = in_bit ^ pred;
  assign win_err_inc = win_err_reg + {{(WE_W-1){1'b0}}, mism};

  // Next-state, history, window and counter logic; nothing moves without in_valid.
  always_comb begin
    state_next     = state_reg;
    hist_next      = hist_reg;
    fill_next      = fill_reg;
    match_next     = match_reg;
    win_pos_next   = win_pos_reg;
    win_err_next   = win_err_reg;
    bit_cnt_next   = bit_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    err_pulse_next = 1'b0;
    lock_lost_next = 1'b0;

    if (in_valid) begin
      case (state_reg)
        HUNT: begin
          hist_next = {hist_reg[14:0], in_bit};
          fill_next = fill_reg + 5'd1;
          if (fill_reg == 5'd15) begin
            state_next = VERIFY;
            match_next = 8'd0;
          end
        end
        VERIFY: begin
          // Keep loading received bits so a slip resynchronises on its own.
          hist_next = {hist_reg[14:0], in_bit};
          if (!mism && (hist_reg != 16'd0)) begin
            match_next = match_reg + 8'd1;
            if (match_reg + 8'd1 == LOCK_U) begin
              state_next   = LOCKED;
              win_pos_next = '0;
              win_err_next = '0;
            end
          end else begin
            match_next = 8'd0;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so one flipped bit costs one error.
          hist_next = {hist_reg[14:0], pred};
          if (bit_cnt_reg != CNT_MAX) bit_cnt_next = bit_cnt_reg + 1'b1;
          if (mism) begin
            err_pulse_next = 1'b1;
            if (err_cnt_reg != CNT_MAX) err_cnt_next = err_cnt_reg + 1'b1;
          end
          if (win_pos_reg == WIN_LAST) begin
            win_pos_next = '0;
            win_err_next = '0;
          end else begin
            win_pos_next = win_pos_reg + 1'b1;
            win_err_next = win_err_inc;
          end
          if ((LOSS_THRESH != 0) && (32'(win_err_inc) >= LOSS_U)) begin
            state_next     = HUNT;
            fill_next      = 5'd0;
            lock_lost_next = 1'b1;
          end
        end
        default: begin
          state_next = HUNT;
          fill_next  = 5'd0;
        end
      endcase
    end

    // A clear wins over any increment made in the same cycle.
    if (clear_cnt) begin
      bit_cnt_next = '0;
      err_cnt_next = '0;
    end

    locked_next = (state_next == LOCKED);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= HUNT;
      hist_reg      <= 16'd0;
      fill_reg      <= 5'd0;
      match_reg     <= 8'd0;
      win_pos_reg   <= '0;
      win_err_reg   <= '0;
      bit_cnt_reg   <= '0;
      err_cnt_reg   <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      lock_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hist_reg      <= hist_next;
      fill_reg      <= fill_next;
      match_reg     <= match_next;
      win_pos_reg   <= win_pos_next;
      win_err_reg   <= win_err_next;
      bit_cnt_reg   <= bit_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      locked_reg    <= locked_next;
      err_pulse_reg <= err_pulse_next;
      lock_lost_reg <= lock_lost_next;
    end
  end

  assign state     = state_reg;
  assign locked    = locked_reg;
  assign bit_count = bit_cnt_reg;
  assign err_count = err_cnt_reg;
  assign err_pulse = err_pulse_reg;
  assign lock_lost = lock_lost_reg;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker: a default instance (A) and a small-counter,
// loss-disabled instance (B). Stream bits come from a local PRBS16 generator.
module tb_prbs16_checker;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default parameters
  logic        reset_a = 1'b1, in_valid_a = 1'b0, in_bit_a = 1'b0, clear_a = 1'b0;
  logic        locked_a, err_pulse_a, lock_lost_a;
  logic [1:0]  state_a;
  logic [31:0] bit_count_a, err_count_a;

  // Instance B: CNT_W=4, LOSS_THRESH=0
  logic        reset_b = 1'b1, in_valid_b = 1'b0, in_bit_b = 1'b0, clear_b = 1'b0;
  logic        locked_b, err_pulse_b, lock_lost_b;
  logic [1:0]  state_b;
  logic [3:0]  bit_count_b, err_count_b;

  prbs16_checker dut_a (
    .clock(clock), .reset(reset_a), .in_valid(in_valid_a), .in_bit(in_bit_a),
    .clear_cnt(clear_a), .locked(locked_a), .state(state_a),
    .bit_count(bit_count_a), .err_count(err_count_a),
    .err_pulse(err_pulse_a), .lock_lost(lock_lost_a)
  );

  prbs16_checker #(.CNT_W(4), .LOSS_THRESH(0)) dut_b (
    .clock(clock), .reset(reset_b), .in_valid(in_valid_b), .in_bit(in_bit_b),
    .clear_cnt(clear_b), .locked(locked_b), .state(state_b),
    .bit_count(bit_count_b), .err_count(err_count_b),
    .err_pulse(err_pulse_b), .lock_lost(lock_lost_b)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] gen;
  int n_locked;

  // Reference generator: output is the feedback bit, shifted into bit 0.
  task automatic gen_step(output logic b);
    b   = gen[15] ^ gen[13] ^ gen[12] ^ gen[10];
    gen = {gen[14:0], b};
  endtask

  task automatic drive_a(input logic v, input logic b, input logic clr);
    @(negedge clock);
    in_valid_a = v; in_bit_a = b; clear_a = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_b(input logic v, input logic b, input logic clr);
    @(negedge clock);
    in_valid_b = v; in_bit_b = b; clear_b = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut_a();
    @(negedge clock);
    reset_a = 1'b1; in_valid_a = 1'b0; in_bit_a = 1'b0; clear_a = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_a = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_a = 1'b1; in_valid_a = 1'b1; in_bit_a = 1'b1; clear_a = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({state_a, locked_a, err_pulse_a, lock_lost_a} !== 5'b0 ||
        bit_count_a !== 32'd0 || err_count_a !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: state=%0d locked=%0b ep=%0b ll=%0b bc=%0d ec=%0d required all 0",
               state_a, locked_a, err_pulse_a, lock_lost_a, bit_count_a, err_count_a);
    end else $display("ok reset_outputs");
    reset_dut_a();
  endtask

  task automatic test_lock();
    logic b;
    gen = 16'h0001;
    for (int i = 1; i <= 48; i++) begin
      gen_step(b);
      drive_a(1'b1, b, 1'b0);
      if (i == 15) begin
        total++;
        if (state_a !== 2'd0) begin bad++; $display("FAIL lock_hunt15: state=%0d required 0", state_a); end
        else $display("ok lock_hunt15");
      end
      if (i == 16) begin
        total++;
        if (state_a !== 2'd1) begin bad++; $display("FAIL lock_verify16: state=%0d required 1", state_a); end
        else $display("ok lock_verify16");
      end
      if (i == 47) begin
        total++;
        if (locked_a !== 1'b0 || state_a !== 2'd1) begin
          bad++; $display("FAIL lock_bit47: locked=%0b state=%0d required 0/1", locked_a, state_a);
        end else $display("ok lock_bit47");
      end
      if (i == 48) begin
        total++;
        if (locked_a !== 1'b1 || state_a !== 2'd2) begin
          bad++; $display("FAIL lock_bit48: locked=%0b state=%0d required 1/2", locked_a, state_a);
        end else $display("ok lock_bit48");
      end
    end
    for (int i = 0; i < 1000; i++) begin
      gen_step(b);
      drive_a(1'b1, b, 1'b0);
    end
    n_locked = 1000;
    total++;
    if (bit_count_a !== 32'd1000 || err_count_a !== 32'd0) begin
      bad++; $display("FAIL lock_counts: bc=%0d ec=%0d required 1000/0", bit_count_a, err_count_a);
    end else $display("ok lock_counts");
  endtask

  task automatic test_single_error();
    logic b;
    for (int i = 1; i <= 101; i++) begin
      gen_step(b);
      if (i == 100) b = ~b;
      drive_a(1'b1, b, 1'b0);
      if (i == 99 || i == 101) begin
        total++;
        if (err_pulse_a !== 1'b0) begin bad++; $display("FAIL single_nopulse%0d: ep=%0b required 0", i, err_pulse_a); end
        else $display("ok single_nopulse%0d", i);
      end
      if (i == 100) begin
        total++;
        if (err_pulse_a !== 1'b1) begin bad++; $display("FAIL single_pulse: ep=%0b required 1", err_pulse_a); end
        else $display("ok single_pulse");
      end
    end
    n_locked += 101;
    total++;
    if (err_count_a !== 32'd1 || bit_count_a !== 32'd1101 || locked_a !== 1'b1) begin
      bad++; $display("FAIL single_counts: ec=%0d bc=%0d locked=%0b required 1/1101/1",
                      err_count_a, bit_count_a, locked_a);
    end else $display("ok single_counts");
  endtask

  task automatic test_burst();
    logic b;
    int pad;
    drive_a(1'b0, 1'b0, 1'b1);
    total++;
    if (bit_count_a !== 32'd0 || err_count_a !== 32'd0) begin
      bad++; $display("FAIL burst_clear: bc=%0d ec=%0d required 0/0", bit_count_a, err_count_a);
    end else $display("ok burst_clear");
    // Align to the start of a fresh loss window.
    pad = 0;
    while ((n_locked % 64) != 0) begin
      gen_step(b);
      drive_a(1'b1, b, 1'b0);
      n_locked++;
      pad++;
    end
    for (int i = 1; i <= 8; i++) begin
      gen_step(b);
      drive_a(1'b1, ~b, 1'b0);
      if (i == 7) begin
        total++;
        if (state_a !== 2'd2 || lock_lost_a !== 1'b0) begin
          bad++; $display("FAIL burst_err7: state=%0d ll=%0b required 2/0", state_a, lock_lost_a);
        end else $display("ok burst_err7");
      end
      if (i == 8) begin
        total++;
        if (lock_lost_a !== 1'b1 || state_a !== 2'd0 || locked_a !== 1'b0) begin
          bad++; $display("FAIL burst_err8: ll=%0b state=%0d locked=%0b required 1/0/0",
                          lock_lost_a, state_a, locked_a);
        end else $display("ok burst_err8");
      end
    end
    total++;
    if (err_count_a !== 32'd8 || bit_count_a !== 32'(pad + 8)) begin
      bad++; $display("FAIL burst_counts: ec=%0d bc=%0d required 8/%0d", err_count_a, bit_count_a, pad + 8);
    end else $display("ok burst_counts");
    for (int i = 1; i <= 48; i++) begin
      gen_step(b);
      drive_a(1'b1, b, 1'b0);
      if (i == 1) begin
        total++;
        if (lock_lost_a !== 1'b0) begin bad++; $display("FAIL burst_ll_once: ll=%0b required 0", lock_lost_a); end
        else $display("ok burst_ll_once");
      end
      if (i == 47) begin
        total++;
        if (locked_a !== 1'b0) begin bad++; $display("FAIL relock_47: locked=%0b required 0", locked_a); end
        else $display("ok relock_47");
      end
      if (i == 48) begin
        total++;
        if (locked_a !== 1'b1 || err_count_a !== 32'd8) begin
          bad++; $display("FAIL relock_48: locked=%0b ec=%0d required 1/8", locked_a, err_count_a);
        end else $display("ok relock_48");
      end
    end
  endtask

  task automatic test_zero();
    logic ever_locked;
    reset_dut_a();
    ever_locked = 1'b0;
    for (int i = 1; i <= 500; i++) begin
      drive_a(1'b1, 1'b0, 1'b0);
      if (locked_a === 1'b1 || state_a === 2'd2) ever_locked = 1'b1;
      if (i == 16) begin
        total++;
        if (state_a !== 2'd1) begin bad++; $display("FAIL zero_verify: state=%0d required 1", state_a); end
        else $display("ok zero_verify");
      end
    end
    total++;
    if (ever_locked !== 1'b0 || state_a !== 2'd1 || locked_a !== 1'b0 ||
        bit_count_a !== 32'd0 || err_count_a !== 32'd0) begin
      bad++; $display("FAIL zero_end: ever=%0b state=%0d locked=%0b bc=%0d ec=%0d required 0/1/0/0/0",
                      ever_locked, state_a, locked_a, bit_count_a, err_count_a);
    end else $display("ok zero_end");
  endtask

  task automatic test_sparse();
    logic b;
    int k;
    reset_dut_a();
    gen = 16'h0001;
    k = 0;
    for (int cyc = 0; k < 48; cyc++) begin
      if (cyc % 3 == 0) begin
        gen_step(b);
        drive_a(1'b1, b, 1'b0);
        k++;
        if (k == 48) begin
          total++;
          if (locked_a !== 1'b1) begin bad++; $display("FAIL sparse_lock48: locked=%0b required 1 (cycle %0d)", locked_a, cyc); end
          else $display("ok sparse_lock48 cycle=%0d", cyc);
        end
      end else begin
        drive_a(1'b0, 1'($urandom), 1'b0);
        if (k == 47) begin
          total++;
          if (locked_a !== 1'b0 || state_a !== 2'd1) begin
            bad++; $display("FAIL sparse_gap47: locked=%0b state=%0d required 0/1", locked_a, state_a);
          end else $display("ok sparse_gap47");
        end
      end
    end
    gen_step(b);
    drive_a(1'b1, b, 1'b0);
    drive_a(1'b0, ~b, 1'b0);
    drive_a(1'b0, b, 1'b0);
    total++;
    if (bit_count_a !== 32'd1 || err_count_a !== 32'd0 || err_pulse_a !== 1'b0 || locked_a !== 1'b1) begin
      bad++; $display("FAIL sparse_hold: bc=%0d ec=%0d ep=%0b locked=%0b required 1/0/0/1",
                      bit_count_a, err_count_a, err_pulse_a, locked_a);
    end else $display("ok sparse_hold");
  endtask

  task automatic test_saturate();
    logic b;
    @(negedge clock);
    reset_b = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_b = 1'b0;
    gen = 16'h0001;
    for (int i = 0; i < 48; i++) begin
      gen_step(b);
      drive_b(1'b1, b, 1'b0);
    end
    total++;
    if (locked_b !== 1'b1) begin bad++; $display("FAIL sat_lock: locked=%0b required 1", locked_b); end
    else $display("ok sat_lock");
    for (int i = 0; i < 40; i++) begin
      gen_step(b);
      drive_b(1'b1, ~b, 1'b0);
    end
    total++;
    if (err_count_b !== 4'd15 || bit_count_b !== 4'd15 || locked_b !== 1'b1 || state_b !== 2'd2) begin
      bad++; $display("FAIL sat_counts: ec=%0d bc=%0d locked=%0b state=%0d required 15/15/1/2",
                      err_count_b, bit_count_b, locked_b, state_b);
    end else $display("ok sat_counts");
    gen_step(b);
    drive_b(1'b1, ~b, 1'b1);
    total++;
    if (err_count_b !== 4'd0 || bit_count_b !== 4'd0 || err_pulse_b !== 1'b1) begin
      bad++; $display("FAIL sat_clear: ec=%0d bc=%0d ep=%0b required 0/0/1", err_count_b, bit_count_b, err_pulse_b);
    end else $display("ok sat_clear");
    gen_step(b);
    drive_b(1'b1, b, 1'b0);
    total++;
    if (err_count_b !== 4'd0 || bit_count_b !== 4'd1) begin
      bad++; $display("FAIL sat_after_clear: ec=%0d bc=%0d required 0/1", err_count_b, bit_count_b);
    end else $display("ok sat_after_clear");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_burst();
    test_zero();
    test_sparse();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
